// File: rtl/vram_mp_if.sv
// Port bundle for vram_mp: PORTS read channels, one write channel and the fill control.
// Handshake: rd_en/wr_en/fill_start are single-cycle strobes with no ready; rd_valid qualifies rd_data, and fill_busy/fill_done report the fill engine.
interface vram_mp_if #(
  parameter int WIDTH  = 12,
  parameter int AWIDTH = 12,
  parameter int PORTS  = 2
);
  logic [PORTS-1:0]  rd_en;
  logic [AWIDTH-1:0] rd_addr [PORTS];
  logic [WIDTH-1:0]  rd_data [PORTS];
  logic [PORTS-1:0]  rd_valid;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              fill_start;
  logic [WIDTH-1:0]  fill_value;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, fill_start, fill_value,
    input  rd_data, rd_valid, fill_busy, fill_done
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, fill_start, fill_value,
    output rd_data, rd_valid, fill_busy, fill_done
  );
endinterface

// File: rtl/vram_mp.sv
// Multi-port video RAM: one write port, PORTS read ports of latency 1 or 2,
// and a fill engine that sweeps every word with a constant value.
module vram_mp #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 4096,
  parameter int PORTS   = 2,
  parameter int LATENCY = 1,
  parameter     INIT    = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  vram_mp_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  fill_state_t       state;
  logic [AWIDTH-1:0] fill_addr;
  logic [WIDTH-1:0]  fill_word;
  logic              busy_q;
  logic              done_q;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  s1_data [PORTS];
  logic [PORTS-1:0]  s1_valid;

  function automatic logic in_range(input logic [AWIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Power-up contents only; reset never touches the array.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  // Fill owns the array while busy; otherwise in-range external writes land.
  always_ff @(posedge clk) begin
    if (state == FILL)
      mem[fill_addr] <= fill_word;
    else if (bus.wr_en && in_range(bus.wr_addr))
      mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_addr <= '0;
      fill_word <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fill_start) begin
            state     <= FILL;
            fill_addr <= '0;
            fill_word <= bus.fill_value;
            busy_q    <= 1'b1;
          end
        end
        FILL: begin
          if (fill_addr == LAST_ADDR) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            fill_addr <= fill_addr + AWIDTH'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Nonblocking array update gives read-first behaviour against any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= '0;
      for (int p = 0; p < PORTS; p++) s1_data[p] <= '0;
    end else begin
      s1_valid <= bus.rd_en;
      for (int p = 0; p < PORTS; p++)
        s1_data[p] <= (bus.rd_en[p] && in_range(bus.rd_addr[p])) ? mem[bus.rd_addr[p]] : '0;
    end
  end

  if (LATENCY == 1) begin : g_lat1
    assign bus.rd_data  = s1_data;
    assign bus.rd_valid = s1_valid;
  end else begin : g_lat2
    logic [WIDTH-1:0] s2_data [PORTS];
    logic [PORTS-1:0] s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= '0;
        for (int p = 0; p < PORTS; p++) s2_data[p] <= '0;
      end else begin
        s2_valid <= s1_valid;
        for (int p = 0; p < PORTS; p++) s2_data[p] <= s1_data[p];
      end
    end

    assign bus.rd_data  = s2_data;
    assign bus.rd_valid = s2_valid;
  end

  assign bus.fill_busy = busy_q;
  assign bus.fill_done = done_q;
  assign dbg_state     = state;
endmodule
